// File: rtl/mul_iterative_param_if.sv
// Request/response bundle for the iterative multiplier: issue side (master)
// drives the operation, the multiplier (slave) returns status and result.
interface mul_iterative_param_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output ready_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_iterative_param.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, retiring BPC
// multiplier bits per cycle on sign-magnitude operands.
module mul_iterative_param #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input logic                 clk,
  input logic                 rst,
  mul_iterative_param_if.slave bus
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   fin_q, fin_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              na_s, nb_s;
  logic [2*XLEN-1:0] pp_s, acc_step_s, prod_s;
  logic [31:0]       shamt_s;
  logic              done_s;

  // Next-state, datapath step and output-register inputs
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    result_d = result_q;
    done_d   = 1'b0;

    na_s = ((bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU)) && bus.a_i[XLEN-1];
    nb_s = (bus.op_i == OP_MULH) && bus.b_i[XLEN-1];

    pp_s       = {{XLEN{1'b0}}, a_q} * {{(2*XLEN-BPC){1'b0}}, b_q[BPC-1:0]};
    shamt_s    = 32'(cnt_q) * 32'(BPC);
    acc_step_s = acc_q + (pp_s << shamt_s);
    // Sign is applied once, on the final magnitude product.
    prod_s     = neg_q ? ({(2*XLEN){1'b0}} - acc_step_s) : acc_step_s;

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d    = bus.op_i;
          a_d     = na_s ? ({XLEN{1'b0}} - bus.a_i) : bus.a_i;
          b_d     = nb_s ? ({XLEN{1'b0}} - bus.b_i) : bus.b_i;
          neg_d   = na_s ^ nb_s;
          acc_d   = {(2*XLEN){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step_s;
          b_d   = b_q >> BPC;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(N - 1)) begin
            fin_d   = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!bus.flush_i) begin
          result_d = fin_q;
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      neg_q    <= 1'b0;
      acc_q    <= {(2*XLEN){1'b0}};
      cnt_q    <= {CW{1'b0}};
      fin_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      result_q <= result_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // A flush in the DONE cycle must hide both the pulse and the new value.
  assign done_s       = done_q & ~bus.flush_i;
  assign bus.done_o   = done_s;
  assign bus.result_o = done_s ? fin_q : result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_mul_iterative_param.sv
// Scoreboard bench for mul_iterative_param: a cycle-level model predicts
// acceptance/completion, a monitor compares every cycle at the falling edge.
module tb_mul_iterative_param;
  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int N    = XLEN / BPC;

  typedef struct {
    logic [XLEN-1:0] res;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_iterative_param_if #(.XLEN(XLEN)) bus ();

  mul_iterative_param #(.XLEN(XLEN), .BPC(BPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t            exp_q[$];
  int              cyc     = 0;
  bit              free    = 1'b1;
  int              free_at = 0;
  logic [XLEN-1:0] last_res = '0;
  bit              use_ovr = 1'b0;
  logic [XLEN-1:0] ovr_val = '0;
  int              n_chk   = 0;
  int              n_fail  = 0;

  function automatic logic [XLEN-1:0] golden(input logic [1:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    sa = {{32{a[31]}}, a};
    ua = {32'h0, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    case (op)
      2'b00:   begin p = ua * ub; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, act, req);
    end
  endtask

  // Reference model: acceptance, flush/reset abort and completion timing
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      free = 1'b1;
      exp_q.delete();
    end else begin
      cyc = cyc + 1;
      if (free) begin
        if (bus.start_i && !bus.flush_i) begin
          exp_q.push_back('{res: use_ovr ? ovr_val : golden(bus.op_i, bus.a_i, bus.b_i),
                            due: cyc + N});
          free    = 1'b0;
          free_at = cyc + N + 1;
        end
      end else if (bus.flush_i) begin
        free = 1'b1;
        exp_q.delete();
      end else if (cyc == free_at) begin
        free = 1'b1;
      end
    end
  end

  // Monitor: status, completion pulse and result compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_ready", bus.ready_o, 1);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_result", bus.result_o, 0);
      last_res = '0;
    end else begin
      chk("ready", bus.ready_o, free);
      chk("busy", bus.busy_o, !free);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("done", bus.done_o, !bus.flush_i);
        if (!bus.flush_i) begin
          chk("result", bus.result_o, e.res);
          last_res = e.res;
        end else begin
          chk("flushed_hold", bus.result_o, last_res);
        end
      end else begin
        chk("no_done", bus.done_o, 0);
        chk("hold", bus.result_o, last_res);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    int k = 0;
    while (!free && k < 200) begin
      step();
      k++;
    end
    if (!free) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_free: model still busy after %0d cycles, required idle", k);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input bit en, input logic [XLEN-1:0] v);
    wait_free();
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    use_ovr     = en;
    ovr_val     = v;
    step();
    bus.start_i = 1'b0;
    use_ovr     = 1'b0;
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    bus.op_i    = 2'($urandom);
  endtask

  function automatic logic [XLEN-1:0] pick();
    logic [XLEN-1:0] c[4] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(3) == 0) return c[$urandom_range(3)];
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    issue(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);

    // Flush mid-calculation, then restart two cycles later
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '0);
    repeat (9) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    issue(2'b00, 32'h0000_1000, 32'h0000_0300, 1'b1, 32'h0030_0000);

    // Flush during the completion cycle suppresses done_o
    issue(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, '0);
    repeat (N) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;

    // Start together with flush while idle is dropped
    wait_free();
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("dropped_start_ready", bus.ready_o, 1);

    // start_i held high with operands changing every cycle
    for (int i = 0; i < 5 * (N + 2); i++) begin
      bus.start_i = 1'b1;
      bus.op_i    = 2'($urandom);
      bus.a_i     = pick();
      bus.b_i     = pick();
      step();
    end
    bus.start_i = 1'b0;

    // Asynchronous reset in the middle of a calculation
    issue(2'b11, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b0, '0);
    repeat (4) step();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ready", bus.ready_o, 1);
    chk("async_rst_busy", bus.busy_o, 0);
    chk("async_rst_done", bus.done_o, 0);
    chk("async_rst_result", bus.result_o, 0);
    step();
    step();
    rst = 1'b0;
    step();
    issue(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF);

    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom), pick(), pick(), 1'b0, '0);
    end
    wait_free();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_iterative_param.md
MUL_ITERATIVE_PARAM -- requirements
Module: mul_iterative_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter BPC, default 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8, dividing XLEN.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  request; accepted only when ready_o=1.
REQ-006 op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; sampled with start_i.
REQ-007 a_i  input  XLEN  rs1 operand; signed for MULH/MULHSU.
REQ-008 b_i  input  XLEN  rs2 operand; signed for MULH only.
REQ-009 flush_i  input  1  abort in-flight operation.
REQ-010 ready_o  output  1  high only in IDLE.
REQ-011 busy_o  output  1  high in CALC and DONE; pipeline stall source.
REQ-012 done_o  output  1  one-cycle pulse, result_o valid.
REQ-013 result_o  output  XLEN  result; holds last value until next done_o.

Function
REQ-014 SHALL implement FSM IDLE, CALC, DONE; N = XLEN/BPC.
REQ-015 IDLE: start_i=1 and flush_i=0 -> latch op, |a|, |b|, result sign; clear product accumulator and counter; go CALC.
REQ-016 Magnitude rules: a negated if MUL-H/HSU and a[XLEN-1]=1; b negated if MULH and b[XLEN-1]=1; MUL and MULHU treat both unsigned; magnitudes held as XLEN-bit unsigned (most-negative value maps to 2^(XLEN-1)).
REQ-017 Result sign = XOR of applied operand negations.
REQ-018 CALC: each cycle add |a| x (low BPC bits of multiplier) shifted by counter*BPC into 2*XLEN accumulator; shift multiplier right BPC; counter+1.
REQ-019 CALC exits to DONE after exactly N cycles; no early termination.
REQ-020 DONE: negate 2*XLEN product (two's complement) if sign=1; result_o <= low XLEN for MUL, high XLEN otherwise; done_o=1 this cycle only; next state IDLE.
REQ-021 Latency: start accepted at edge T -> done_o high in cycle T+N+1 (33 cycles for defaults); back-to-back start accepted in cycle after done_o.
REQ-022 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-023 flush_i in CALC or DONE -> IDLE at next edge, done_o not asserted, result_o unchanged; flush_i in IDLE with start_i -> request dropped.
REQ-024 flush_i has priority over completion in DONE: done_o SHALL be 0 when flush_i=1.
REQ-025 Operand inputs SHALL not be used after acceptance cycle; changing a_i/b_i/op_i mid-operation has no effect.
REQ-026 All products SHALL be exact (mod 2^(2*XLEN)) for every operand pair.

Reset
REQ-027 rst=1 -> state IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, accumulator/counter/latched operands 0, immediately and asynchronously.
REQ-028 rst asserted mid-CALC SHALL abort without done_o; first start after deassert behaves normally.

Verification
REQ-029 MUL, a=0x0000_0007, b=0xFFFF_FFFD -> result 0xFFFF_FFEB, done_o at T+33, ready_o low T+1..T+33.
REQ-030 MULH a=b=0x8000_0000 -> 0x4000_0000; MULHU a=b=0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> 0xFFFF_FFFF.
REQ-031 BPC=4 build, MULH a=0xFFFF_FFFE, b=0x0000_0003 -> 0xFFFF_FFFF, done_o at T+9.
REQ-032 flush_i at T+10 of a MUL -> no done_o, result_o keeps prior value, new start at T+12 completes at T+12+33 correctly.
REQ-033 start_i held high continuously with changing operands -> only operands at accepted edges used; done_o pulses every 34 cycles.
REQ-034 rst pulse at T+5 mid-CALC -> all outputs reset values same cycle, no done_o; random 10k-vector compare against 64-bit golden model for all ops.
